// File: rtl/cache_pkg.sv
// Shared types and widths for the direct-mapped write-back cache controller.
package cache;

  localparam int unsigned TAG_W    = 18;
  localparam int unsigned INDEX_W  = 10;
  localparam int unsigned OFFSET_W = 4;
  localparam int unsigned LINE_W   = 128;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic               we;
  } cache_req_t;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } cache_tag_t;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StCompare,
    StWriteback,
    StAllocReq,
    StAllocWait
  } cache_state_t;

  // Selects one 32-bit word out of a cache line.
  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line, input logic [1:0] word);
    return line[32*word +: 32];
  endfunction

endpackage

// File: rtl/cache_controller.sv
// Blocking write-back, write-allocate controller sequencing tag/data arrays of a
// direct-mapped cache between a CPU load/store port and line-wide main memory.
module cache_controller
  import cache::*;
#(
  parameter int unsigned SETS = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req_valid,
  output logic                cpu_req_ready,
  input  logic                cpu_req_rw,
  input  logic [31:0]         cpu_req_addr,
  input  logic [31:0]         cpu_req_wdata,
  output logic                cpu_resp_valid,
  output logic [31:0]         cpu_resp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_rw,
  output logic [31:0]         mem_req_addr,
  output logic [LINE_W-1:0]   mem_req_wdata,
  input  logic                mem_resp_valid,
  input  logic [LINE_W-1:0]   mem_resp_rdata,
  output cache_req_t          tag_req,
  output cache_tag_t          tag_write,
  input  cache_tag_t          tag_read,
  output cache_req_t          data_req,
  output logic [LINE_W-1:0]   data_write,
  input  logic [LINE_W-1:0]   data_read
);

  localparam logic [INDEX_W-1:0] LastIdx = INDEX_W'(SETS - 1);

  cache_state_t       state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [1:0]         word_q, word_d;
  logic               rw_q, rw_d;
  logic [31:0]        wdata_q, wdata_d;

  logic               hit;
  logic [LINE_W-1:0]  merged_line;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      cnt_q   <= '0;
      tag_q   <= '0;
      index_q <= '0;
      word_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      index_q <= index_d;
      word_q  <= word_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
    end
  end

  assign hit = tag_read.valid && (tag_read.tag == tag_q);

  always_comb begin
    merged_line = data_read;
    merged_line[32*word_q +: 32] = wdata_q;
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    tag_d          = tag_q;
    index_d        = index_q;
    word_d         = word_q;
    rw_d           = rw_q;
    wdata_d        = wdata_q;

    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_rdata = '0;
    mem_req_valid  = 1'b0;
    mem_req_rw     = 1'b0;
    mem_req_addr   = '0;
    mem_req_wdata  = '0;
    tag_req.index  = index_q;
    tag_req.we     = 1'b0;
    tag_write      = '0;
    data_req.index = index_q;
    data_req.we    = 1'b0;
    data_write     = '0;

    unique case (state_q)
      StInit: begin
        tag_req.index = cnt_q;
        tag_req.we    = 1'b1;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      StIdle: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) begin
          tag_d   = cpu_req_addr[31:14];
          index_d = cpu_req_addr[13:4];
          word_d  = cpu_req_addr[3:2];
          rw_d    = cpu_req_rw;
          wdata_d = cpu_req_wdata;
          state_d = StCompare;
        end
      end
      StCompare: begin
        if (hit) begin
          cpu_resp_valid = 1'b1;
          state_d        = StIdle;
          if (rw_q) begin
            data_req.we = 1'b1;
            data_write  = merged_line;
            tag_req.we  = 1'b1;
            tag_write   = '{valid: 1'b1, dirty: 1'b1, tag: tag_q};
          end else begin
            cpu_resp_rdata = line_word(data_read, word_q);
          end
        end else if (tag_read.valid && tag_read.dirty) begin
          state_d = StWriteback;
        end else begin
          state_d = StAllocReq;
        end
      end
      StWriteback: begin
        // Victim address comes from the resident tag, not the requested one.
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {tag_read.tag, index_q, {OFFSET_W{1'b0}}};
        mem_req_wdata = data_read;
        if (mem_req_ready) state_d = StAllocReq;
      end
      StAllocReq: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {tag_q, index_q, {OFFSET_W{1'b0}}};
        if (mem_req_ready) state_d = StAllocWait;
      end
      StAllocWait: begin
        if (mem_resp_valid) begin
          data_req.we = 1'b1;
          data_write  = mem_resp_rdata;
          tag_req.we  = 1'b1;
          tag_write   = '{valid: 1'b1, dirty: 1'b0, tag: tag_q};
          state_d     = StCompare;
        end
      end
      default: state_d = StInit;
    endcase

    // Reset silences every output in the same cycle, even mid-transaction.
    if (rst) begin
      cpu_req_ready  = 1'b0;
      cpu_resp_valid = 1'b0;
      cpu_resp_rdata = '0;
      mem_req_valid  = 1'b0;
      mem_req_rw     = 1'b0;
      mem_req_addr   = '0;
      mem_req_wdata  = '0;
      tag_req        = '0;
      tag_write      = '0;
      data_req       = '0;
      data_write     = '0;
    end
  end

endmodule
